// File: rtl/game_pkg.sv
// game_pkg: shared encodings for the Flappy Bird game sequencer.
//   state_e       - sequencer state encoding (IDLE..OVER; 6/7 are illegal)
//   bird_status_e - bird status codes driven to the physics/render side
//   ctrl_t        - registered per-state gating bundle (run_world, run_bird, status)
//   ctrl_of()     - gating bundle that belongs to a given state
//   to_bcd3()     - decimal constant to 3-digit packed BCD
package game_pkg;

  localparam int BCD_W   = 4;
  localparam int SCORE_W = 3 * BCD_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_HIT   = 3'd3,
    S_FALL  = 3'd4,
    S_OVER  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    BS_HOVER  = 2'd0,
    BS_FLYING = 2'd1,
    BS_DEAD   = 2'd2
  } bird_status_e;

  typedef struct packed {
    logic         run_world;
    logic         run_bird;
    bird_status_e status;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_e s);
    ctrl_t c;
    c = '{1'b1, 1'b0, BS_HOVER};
    case (s)
      S_IDLE:  c = '{1'b1, 1'b0, BS_HOVER};   // title-screen scroll
      S_READY: c = '{1'b0, 1'b0, BS_HOVER};
      S_PLAY:  c = '{1'b1, 1'b1, BS_FLYING};
      S_HIT:   c = '{1'b0, 1'b0, BS_DEAD};    // freeze frame after impact
      S_FALL:  c = '{1'b0, 1'b1, BS_DEAD};    // bird drops, world stays still
      S_OVER:  c = '{1'b0, 1'b0, BS_DEAD};
      default: c = '{1'b1, 1'b0, BS_HOVER};
    endcase
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] to_bcd3(input int unsigned v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// bcd_counter3: 3-digit packed BCD counter with clear and saturating increment.
//   clk, rstn - clock, synchronous active-low reset
//   clr       - load zero (wins over inc)
//   inc       - add one, holding once MAX_BCD is reached
//   cmp       - BCD value to compare against
//   value     - current count
//   gt        - value > cmp (combinational)
module bcd_counter3 import game_pkg::*; #(
  parameter logic [SCORE_W-1:0] MAX_BCD = 12'h999
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               inc,
  input  logic [SCORE_W-1:0] cmp,
  output logic [SCORE_W-1:0] value,
  output logic               gt
);

  logic [BCD_W-1:0]   d0, d1, d2;
  logic [SCORE_W-1:0] nxt;

  // Ripple the decimal carry digit by digit.
  always_comb begin
    d0 = value[3:0];
    d1 = value[7:4];
    d2 = value[11:8];
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    nxt = {d2, d1, d0};
  end

  always_ff @(posedge clk) begin
    if (!rstn)                       value <= '0;
    else if (clr)                    value <= '0;
    else if (inc && value < MAX_BCD) value <= nxt;
  end

  // Valid BCD orders the same as the packed binary word.
  assign gt = (value > cmp);

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer (title/ready/play/hit/fall/over).
//   clk, rstn    - pixel clock, synchronous active-low reset
//   button_pulse - one-cycle debounced press
//   new_frame    - one-cycle pulse per video frame
//   collide      - bird overlaps a pipe (level)
//   on_ground    - bird touches the stage (level)
//   pipe_passed  - one-cycle pulse when a pipe is cleared
//   state        - current state encoding
//   world_reset  - one-cycle reload of bird/pipe positions
//   run_world    - stage and pipes advance
//   run_bird     - bird physics enabled
//   flap         - one-cycle upward impulse
//   bird_status  - 0 hover, 1 flying, 2 dead
//   score, best  - 3-digit BCD current and best score
module game_ctrl import game_pkg::*; #(
  parameter int HIT_FRAMES       = 20,
  parameter int OVER_LOCK_FRAMES = 45,
  parameter int SCORE_MAX        = 999
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         button_pulse,
  input  logic         new_frame,
  input  logic         collide,
  input  logic         on_ground,
  input  logic         pipe_passed,
  output logic [2:0]   state,
  output logic         world_reset,
  output logic         run_world,
  output logic         run_bird,
  output logic         flap,
  output logic [1:0]   bird_status,
  output logic [11:0]  score,
  output logic [11:0]  best
);

  localparam logic [7:0]         HIT_CNT   = 8'(HIT_FRAMES);
  localparam logic [7:0]         LOCK_CNT  = 8'(OVER_LOCK_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX_BCD = to_bcd3(32'(SCORE_MAX));

  state_e      st;
  ctrl_t       ctrl;
  logic [7:0]  frame_cnt;
  logic        hit_now, over_unlock, score_inc, score_clr, score_gt;

  // Ground contact ends a run exactly like a pipe hit.
  assign hit_now     = collide | on_ground;
  assign over_unlock = (st == S_OVER) && (frame_cnt == LOCK_CNT);

  // A hit in the same cycle swallows the pipe credit.
  assign score_inc = (st == S_PLAY) && pipe_passed && !hit_now;
  assign score_clr = button_pulse && ((st == S_IDLE) || over_unlock);

  bcd_counter3 #(.MAX_BCD(SCORE_MAX_BCD)) u_score (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (score_clr),
    .inc   (score_inc),
    .cmp   (best),
    .value (score),
    .gt    (score_gt)
  );

  assign state       = st;
  assign run_world   = ctrl.run_world;
  assign run_bird    = ctrl.run_bird;
  assign bird_status = ctrl.status;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st          <= S_IDLE;
      ctrl        <= ctrl_of(S_IDLE);
      world_reset <= 1'b1;
      flap        <= 1'b0;
      frame_cnt   <= '0;
      best        <= '0;
    end else begin
      world_reset <= 1'b0;
      flap        <= 1'b0;
      // Free-running frame count; holds at the lock value in OVER.
      // Every transition below overrides it with a clear.
      if (new_frame && !over_unlock) frame_cnt <= frame_cnt + 8'd1;

      case (st)
        S_IDLE: if (button_pulse) begin
          st          <= S_READY;
          ctrl        <= ctrl_of(S_READY);
          world_reset <= 1'b1;
          frame_cnt   <= '0;
        end
        S_READY: if (button_pulse) begin
          st        <= S_PLAY;
          ctrl      <= ctrl_of(S_PLAY);
          flap      <= 1'b1;
          frame_cnt <= '0;
        end
        S_PLAY: begin
          if (hit_now) begin
            st        <= S_HIT;
            ctrl      <= ctrl_of(S_HIT);
            frame_cnt <= '0;
          end else if (button_pulse) begin
            flap <= 1'b1;
          end
        end
        S_HIT: if (frame_cnt == HIT_CNT) begin
          st        <= S_FALL;
          ctrl      <= ctrl_of(S_FALL);
          frame_cnt <= '0;
        end
        S_FALL: if (on_ground) begin
          st        <= S_OVER;
          ctrl      <= ctrl_of(S_OVER);
          frame_cnt <= '0;
          if (score_gt) best <= score;
        end
        S_OVER: if (button_pulse && over_unlock) begin
          st          <= S_READY;
          ctrl        <= ctrl_of(S_READY);
          world_reset <= 1'b1;
          frame_cnt   <= '0;
        end
        default: begin
          st        <= S_IDLE;
          ctrl      <= ctrl_of(S_IDLE);
          frame_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        button_pulse = 1'b0, new_frame = 1'b0, collide = 1'b0;
  logic        on_ground = 1'b0, pipe_passed = 1'b0;
  logic [2:0]  state;
  logic        world_reset, run_world, run_bird, flap;
  logic [1:0]  bird_status;
  logic [11:0] score, best;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain decimal score/best.
  int m_score = 0;
  int m_best  = 0;

  always #5 clk = ~clk;

  game_ctrl #(.HIT_FRAMES(20), .OVER_LOCK_FRAMES(45), .SCORE_MAX(999)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .button_pulse (button_pulse),
    .new_frame    (new_frame),
    .collide      (collide),
    .on_ground    (on_ground),
    .pipe_passed  (pipe_passed),
    .state        (state),
    .world_reset  (world_reset),
    .run_world    (run_world),
    .run_bird     (run_bird),
    .flap         (flap),
    .bird_status  (bird_status),
    .score        (score),
    .best         (best)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // {state, world_reset, run_world, run_bird, flap, bird_status}
  function automatic logic [8:0] ev(input int s, input bit wr, input bit rw,
                                    input bit rb, input bit fl, input int bs);
    return {3'(s), wr, rw, rb, fl, 2'(bs)};
  endfunction

  function automatic logic [8:0] obs();
    return {state, world_reset, run_world, run_bird, flap, bird_status};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    button_pulse = 1'b1; tick(); button_pulse = 1'b0;
  endtask

  task automatic frame();
    new_frame = 1'b1; tick(); new_frame = 1'b0;
  endtask

  task automatic pipe();
    pipe_passed = 1'b1; tick(); pipe_passed = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame();
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (obs() !== ev(0, 1, 1, 0, 0, 0) || score !== 12'h000 || best !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_values: got ctl=%b score=%h best=%h want ctl=%b score=000 best=000",
               obs(), score, best, ev(0, 1, 1, 0, 0, 0));
    end
    rstn = 1'b1;
    n_tests++;
    if (world_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wr_first: got %b want 1", world_reset);
    end
    tick();
    n_tests++;
    if (obs() !== ev(0, 0, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_wr_single: got %b want %b", obs(), ev(0, 0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_start();
    press();
    n_tests++;
    if (obs() !== ev(1, 1, 0, 0, 0, 0) || score !== 12'h000) begin
      n_fail++;
      $display("FAIL idle_to_ready: got ctl=%b score=%h want ctl=%b score=000",
               obs(), score, ev(1, 1, 0, 0, 0, 0));
    end
    tick();
    n_tests++;
    if (obs() !== ev(1, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL ready_idle: got %b want %b", obs(), ev(1, 0, 0, 0, 0, 0));
    end
    press();
    n_tests++;
    if (obs() !== ev(2, 0, 1, 1, 1, 1)) begin
      n_fail++;
      $display("FAIL ready_to_play: got %b want %b", obs(), ev(2, 0, 1, 1, 1, 1));
    end
    tick();
    n_tests++;
    if (obs() !== ev(2, 0, 1, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL play_flap_single: got %b want %b", obs(), ev(2, 0, 1, 1, 0, 1));
    end
    m_score = 0;
  endtask

  // Random mix of idle, pipe, press and pipe+press until the model reaches target.
  task automatic test_play_random(input int target);
    int act;
    while (m_score < target) begin
      act = $urandom_range(0, 3);
      pipe_passed  = (act == 1 || act == 3);
      button_pulse = (act == 2 || act == 3);
      tick();
      pipe_passed  = 1'b0;
      button_pulse = 1'b0;
      if (act == 1 || act == 3) m_score = (m_score < 999) ? m_score + 1 : 999;
      n_tests++;
      if (score !== bcd(m_score) || flap !== (act >= 2) || state !== 3'd2) begin
        n_fail++;
        $display("FAIL play_step: got score=%h flap=%b state=%0d want score=%h flap=%b state=2",
                 score, flap, state, bcd(m_score), (act >= 2));
      end
    end
  endtask

  task automatic test_score_boundaries();
    test_play_random(12);
    n_tests++;
    if (score !== 12'h012) begin
      n_fail++;
      $display("FAIL score_12: got %h want 012", score);
    end
    test_play_random(99);
    pipe();
    m_score = 100;
    n_tests++;
    if (score !== 12'h100) begin
      n_fail++;
      $display("FAIL score_carry: got %h want 100", score);
    end
    test_play_random(999);
    pipe();
    n_tests++;
    if (score !== 12'h999) begin
      n_fail++;
      $display("FAIL score_saturate: got %h want 999", score);
    end
  endtask

  // Collision ends the run; exit via a normal ground touch in FALL.
  task automatic test_collide_priority();
    collide = 1'b1; pipe_passed = 1'b1; button_pulse = 1'b1;
    tick();
    collide = 1'b0; pipe_passed = 1'b0; button_pulse = 1'b0;
    n_tests++;
    if (obs() !== ev(3, 0, 0, 0, 0, 2) || score !== bcd(m_score)) begin
      n_fail++;
      $display("FAIL hit_priority: got ctl=%b score=%h want ctl=%b score=%h",
               obs(), score, ev(3, 0, 0, 0, 0, 2), bcd(m_score));
    end
    press();
    pipe();
    n_tests++;
    if (obs() !== ev(3, 0, 0, 0, 0, 2) || score !== bcd(m_score)) begin
      n_fail++;
      $display("FAIL hit_ignore: got ctl=%b score=%h want ctl=%b score=%h",
               obs(), score, ev(3, 0, 0, 0, 0, 2), bcd(m_score));
    end
    frames(19);
    tick();
    n_tests++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL hit_hold_19: got %0d want 3", state);
    end
    frame();
    tick();
    n_tests++;
    if (obs() !== ev(4, 0, 0, 1, 0, 2)) begin
      n_fail++;
      $display("FAIL hit_to_fall: got %b want %b", obs(), ev(4, 0, 0, 1, 0, 2));
    end
    press();
    n_tests++;
    if (obs() !== ev(4, 0, 0, 1, 0, 2)) begin
      n_fail++;
      $display("FAIL fall_no_flap: got %b want %b", obs(), ev(4, 0, 0, 1, 0, 2));
    end
    on_ground = 1'b1; tick(); on_ground = 1'b0;
    if (m_score > m_best) m_best = m_score;
    n_tests++;
    if (obs() !== ev(5, 0, 0, 0, 0, 2) || best !== bcd(m_best)) begin
      n_fail++;
      $display("FAIL fall_to_over: got ctl=%b best=%h want ctl=%b best=%h",
               obs(), best, ev(5, 0, 0, 0, 0, 2), bcd(m_best));
    end
  endtask

  // Run ended by the ground with on_ground held through HIT.
  task automatic test_ground_special();
    on_ground = 1'b1;
    tick();
    n_tests++;
    if (state !== 3'd3 || score !== bcd(m_score)) begin
      n_fail++;
      $display("FAIL ground_hit: got state=%0d score=%h want state=3 score=%h",
               state, score, bcd(m_score));
    end
    frames(20);
    tick();
    n_tests++;
    if (obs() !== ev(4, 0, 0, 1, 0, 2)) begin
      n_fail++;
      $display("FAIL ground_fall: got %b want %b", obs(), ev(4, 0, 0, 1, 0, 2));
    end
    tick();
    on_ground = 1'b0;
    if (m_score > m_best) m_best = m_score;
    n_tests++;
    if (state !== 3'd5 || best !== bcd(m_best)) begin
      n_fail++;
      $display("FAIL ground_over: got state=%0d best=%h want state=5 best=%h",
               state, best, bcd(m_best));
    end
  endtask

  task automatic test_over_lock();
    frames(10);
    press();
    n_tests++;
    if (state !== 3'd5 || score !== bcd(m_score)) begin
      n_fail++;
      $display("FAIL over_lock_10: got state=%0d score=%h want state=5 score=%h",
               state, score, bcd(m_score));
    end
    frames(34);
    press();
    n_tests++;
    if (state !== 3'd5) begin
      n_fail++;
      $display("FAIL over_lock_44: got %0d want 5", state);
    end
    frames(3);
    press();
    m_score = 0;
    n_tests++;
    if (obs() !== ev(1, 1, 0, 0, 0, 0) || score !== 12'h000 || best !== bcd(m_best)) begin
      n_fail++;
      $display("FAIL over_release: got ctl=%b score=%h best=%h want ctl=%b score=000 best=%h",
               obs(), score, best, ev(1, 1, 0, 0, 0, 0), bcd(m_best));
    end
    pipe();
    n_tests++;
    if (score !== 12'h000 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL ready_pipe_ignored: got score=%h state=%0d want score=000 state=1",
               score, state);
    end
  endtask

  task automatic test_restart();
    frames(45 + $urandom_range(0, 10));
    press();
    m_score = 0;
    n_tests++;
    if (obs() !== ev(1, 1, 0, 0, 0, 0) || score !== 12'h000) begin
      n_fail++;
      $display("FAIL restart_ready: got ctl=%b score=%h want ctl=%b score=000",
               obs(), score, ev(1, 1, 0, 0, 0, 0));
    end
    press();
    n_tests++;
    if (obs() !== ev(2, 0, 1, 1, 1, 1)) begin
      n_fail++;
      $display("FAIL restart_play: got %b want %b", obs(), ev(2, 0, 1, 1, 1, 1));
    end
  endtask

  task automatic test_midgame_reset();
    rstn = 1'b0;
    tick();
    m_score = 0;
    m_best  = 0;
    n_tests++;
    if (obs() !== ev(0, 1, 1, 0, 0, 0) || score !== 12'h000 || best !== 12'h000) begin
      n_fail++;
      $display("FAIL midgame_reset: got ctl=%b score=%h best=%h want ctl=%b score=000 best=000",
               obs(), score, best, ev(0, 1, 1, 0, 0, 0));
    end
    rstn = 1'b1;
    tick();
    n_tests++;
    if (obs() !== ev(0, 0, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL midgame_release: got %b want %b", obs(), ev(0, 0, 1, 0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_start();              // game 1
    test_play_random(5);
    test_collide_priority();   // best 5
    test_over_lock();
    press();                   // game 2
    test_play_random(7);
    test_ground_special();     // best 7
    test_restart();            // game 3
    test_play_random(3);
    test_collide_priority();   // best stays 7
    n_tests++;
    if (best !== 12'h007) begin
      n_fail++;
      $display("FAIL best_kept: got %h want 007", best);
    end
    test_restart();            // game 4
    test_score_boundaries();
    test_midgame_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
